// File: rtl/apxmul_pipe.sv
// Three-stage valid/ready pipelined multiplier with a per-beat exact or approximate (OR-compressed low rows) mode.
// Define APXMUL_ERRSTAT_EN to add the approximation error statistics ports (stat_clr, err_cnt, err_sum, err_max).
module apxmul_pipe #(
  parameter int W    = 8,
  parameter int L    = 6,
  parameter int T    = W,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  input  logic            in_exact,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_z,
  output logic [TAGW-1:0] out_tag,
  output logic            out_exact
`ifdef APXMUL_ERRSTAT_EN
  ,
  input  logic            stat_clr,
  output logic [15:0]     err_cnt,
  output logic [31:0]     err_sum,
  output logic [2*W-1:0]  err_max
`endif
);
  localparam int ZW = 2 * W;
  localparam int NP = L / 2;
  localparam logic [ZW-1:0] TMASK = {ZW{1'b1}} << T;

  logic s1_ready, s2_ready, s3_ready;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic s1_exact_q, s1_exact_d, s2_exact_q, s2_exact_d, s3_exact_q, s3_exact_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, s3_tag_q, s3_tag_d;
  logic [ZW-1:0] s2_hi_q, s2_hi_d, s2_lo_q, s2_lo_d, s3_z_q, s3_z_d;
  logic [ZW-1:0] y_ext, x_hi_ext, x_lo_ext;
  logic [NP:0][ZW-1:0] acc;

  assign y_ext    = {{W{1'b0}}, s1_y_q};
  assign x_hi_ext = {{(W+L){1'b0}}, s1_x_q[W-1:L]};
  assign x_lo_ext = {{(ZW-L){1'b0}}, s1_x_q[L-1:0]};

  // Each row pair collapses to one OR-ed row; only columns at or above T survive.
  assign acc[0] = '0;
  for (genvar k = 0; k < NP; k++) begin : g_pair
    logic [ZW-1:0] pair_or;
    assign pair_or = (({ZW{s1_x_q[2*k]}} & (y_ext << (2*k))) |
                      ({ZW{s1_x_q[2*k+1]}} & (y_ext << (2*k+1)))) & TMASK;
    assign acc[k+1] = acc[k] + pair_or;
  end

  always_comb begin
    s3_ready = !s3_v_q || out_ready;
    s2_ready = !s2_v_q || s3_ready;
    s1_ready = !s1_v_q || s2_ready;

    s1_v_d     = s1_ready ? in_valid : s1_v_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_exact_d = s1_exact_q;
    s1_tag_d   = s1_tag_q;
    if (s1_ready && in_valid) begin
      s1_x_d     = in_x;
      s1_y_d     = in_y;
      s1_exact_d = in_exact;
      s1_tag_d   = in_tag;
    end

    s2_v_d     = s2_ready ? s1_v_q : s2_v_q;
    s2_hi_d    = s2_hi_q;
    s2_lo_d    = s2_lo_q;
    s2_exact_d = s2_exact_q;
    s2_tag_d   = s2_tag_q;
    if (s2_ready && s1_v_q) begin
      s2_hi_d    = (x_hi_ext * y_ext) << L;
      s2_lo_d    = s1_exact_q ? (x_lo_ext * y_ext) : acc[NP];
      s2_exact_d = s1_exact_q;
      s2_tag_d   = s1_tag_q;
    end

    s3_v_d     = s3_ready ? s2_v_q : s3_v_q;
    s3_z_d     = s3_z_q;
    s3_exact_d = s3_exact_q;
    s3_tag_d   = s3_tag_q;
    if (s3_ready && s2_v_q) begin
      s3_z_d     = s2_hi_q + s2_lo_q;
      s3_exact_d = s2_exact_q;
      s3_tag_d   = s2_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0; s1_x_q <= '0; s1_y_q <= '0; s1_exact_q <= 1'b0; s1_tag_q <= '0;
      s2_v_q <= 1'b0; s2_hi_q <= '0; s2_lo_q <= '0; s2_exact_q <= 1'b0; s2_tag_q <= '0;
      s3_v_q <= 1'b0; s3_z_q <= '0; s3_exact_q <= 1'b0; s3_tag_q <= '0;
    end else begin
      s1_v_q <= s1_v_d; s1_x_q <= s1_x_d; s1_y_q <= s1_y_d; s1_exact_q <= s1_exact_d; s1_tag_q <= s1_tag_d;
      s2_v_q <= s2_v_d; s2_hi_q <= s2_hi_d; s2_lo_q <= s2_lo_d; s2_exact_q <= s2_exact_d; s2_tag_q <= s2_tag_d;
      s3_v_q <= s3_v_d; s3_z_q <= s3_z_d; s3_exact_q <= s3_exact_d; s3_tag_q <= s3_tag_d;
    end
  end

  // Reset forces ready high even though the stage flags only clear at the edge.
  assign in_ready  = s1_ready || rst;
  assign out_valid = s3_v_q;
  assign out_z     = s3_z_q;
  assign out_tag   = s3_tag_q;
  assign out_exact = s3_exact_q;

`ifdef APXMUL_ERRSTAT_EN
  logic [ZW-1:0] s2_prod_q, s2_prod_d, s3_prod_q, s3_prod_d, err_abs;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] err_sum_q, err_sum_d;
  logic [ZW-1:0] err_max_q, err_max_d;
  logic [32:0] sum_ext;

  // The exact product travels alongside the beat so the error is known at the output.
  always_comb begin
    s2_prod_d = s2_prod_q;
    if (s2_ready && s1_v_q) s2_prod_d = {{W{1'b0}}, s1_x_q} * y_ext;
    s3_prod_d = s3_prod_q;
    if (s3_ready && s2_v_q) s3_prod_d = s2_prod_q;

    err_abs = (s3_prod_q >= s3_z_q) ? (s3_prod_q - s3_z_q) : (s3_z_q - s3_prod_q);
    sum_ext = {1'b0, err_sum_q} + {{(33-ZW){1'b0}}, err_abs};

    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    if (stat_clr) begin
      err_cnt_d = '0;
      err_sum_d = '0;
      err_max_d = '0;
    end else if (s3_v_q && out_ready && !s3_exact_q) begin
      err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      err_sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
      err_max_d = (err_abs > err_max_q) ? err_abs : err_max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_prod_q <= '0; s3_prod_q <= '0;
      err_cnt_q <= '0; err_sum_q <= '0; err_max_q <= '0;
    end else begin
      s2_prod_q <= s2_prod_d; s3_prod_q <= s3_prod_d;
      err_cnt_q <= err_cnt_d; err_sum_q <= err_sum_d; err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
`endif
endmodule

// File: tb/tb_apxmul_pipe.sv
// Scoreboard bench for apxmul_pipe: a driver pushes reference results, a monitor pops them at each output handshake.
module tb_apxmul_pipe;
  localparam int W = 8, L = 6, T = 8, TAGW = 4, ZW = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_exact, out_valid, out_ready, out_exact;
  logic [W-1:0] in_x, in_y;
  logic [TAGW-1:0] in_tag, out_tag;
  logic [ZW-1:0] out_z;
`ifdef APXMUL_ERRSTAT_EN
  logic stat_clr;
  logic [15:0] err_cnt;
  logic [31:0] err_sum;
  logic [ZW-1:0] err_max;
`endif

  apxmul_pipe #(.W(W), .L(L), .T(T), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_exact(in_exact), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_tag(out_tag), .out_exact(out_exact)
`ifdef APXMUL_ERRSTAT_EN
    , .stat_clr(stat_clr), .err_cnt(err_cnt), .err_sum(err_sum), .err_max(err_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint z;
    longint tag;
    longint exact;
  } exp_t;

  exp_t sb[$];
  int check_cnt = 0;
  int pass_cnt = 0;
  int acc_cnt = 0;
  bit rand_ready = 1'b0;

  // Reference built column by column from the partial-product definition.
  function automatic longint refModel(int x, int y, bit exact);
    longint p;
    int a, b;
    if (exact) begin
      p = longint'(x) * longint'(y);
    end else begin
      p = (longint'(x >> L) * longint'(y)) << L;
      for (int k = 0; k < L / 2; k++) begin
        for (int c = T; c < 2 * W; c++) begin
          a = 0;
          b = 0;
          if (c - 2 * k >= 0 && c - 2 * k < W)
            a = ((x >> (2 * k)) & 1) & ((y >> (c - 2 * k)) & 1);
          if (c - 2 * k - 1 >= 0 && c - 2 * k - 1 < W)
            b = ((x >> (2 * k + 1)) & 1) & ((y >> (c - 2 * k - 1)) & 1);
          p = p + (longint'(a | b) << c);
        end
      end
    end
    return p & ((longint'(1) << (2 * W)) - 1);
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input int x, input int y, input bit exact, input int tag, input longint forced);
    exp_t e;
    int waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x[W-1:0];
    in_y     = y[W-1:0];
    in_exact = exact;
    in_tag   = tag[TAGW-1:0];
    forever begin
      #1;
      if (in_ready) begin
        e.z     = (forced >= 0) ? forced : refModel(x, y, exact);
        e.tag   = longint'(tag);
        e.exact = longint'(exact);
        sb.push_back(e);
        acc_cnt++;
        @(posedge clk);
        break;
      end
      @(posedge clk);
      waits++;
      if (waits > 200) begin
        checkOutput("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty", longint'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Random backpressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each output handshake against the queue and check stall stability.
  initial begin
    logic held;
    logic [ZW-1:0] held_z;
    logic [TAGW-1:0] held_tag;
    logic held_exact;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("hold_valid", longint'(out_valid), 1);
          checkOutput("hold_z", longint'(out_z), longint'(held_z));
          checkOutput("hold_tag", longint'(out_tag), longint'(held_tag));
          checkOutput("hold_exact", longint'(out_exact), longint'(held_exact));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("stale_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("out_z", longint'(out_z), e.z);
            checkOutput("out_tag", longint'(out_tag), e.tag);
            checkOutput("out_exact", longint'(out_exact), e.exact);
          end
        end
        held       = out_valid && !out_ready;
        held_z     = out_z;
        held_tag   = out_tag;
        held_exact = out_exact;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int base;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; in_exact = 1'b0; in_tag = '0;
`ifdef APXMUL_ERRSTAT_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_out_z", longint'(out_z), 0);
    checkOutput("reset_out_tag", longint'(out_tag), 0);
    checkOutput("reset_out_exact", longint'(out_exact), 0);
    checkOutput("reset_in_ready", longint'(in_ready), 1);
    rst = 1'b0;

    // Directed values with known products; the first one also measures latency.
    applyStimulus(255, 255, 1'b0, 3, 58944);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("latency", longint'(lat), 3);
    applyStimulus(255, 255, 1'b1, 4, 65025);
    applyStimulus(1, 1, 1'b0, 5, 0);
    applyStimulus(1, 1, 1'b1, 6, 1);
    applyStimulus(192, 255, 1'b0, 7, 48960);
    drain();
`ifdef APXMUL_ERRSTAT_EN
    checkOutput("err_cnt", longint'(err_cnt), 3);
    checkOutput("err_sum", longint'(err_sum), 6082);
    checkOutput("err_max", longint'(err_max), 6081);
`endif

    // Ten back-to-back beats against a stalled output.
    @(negedge clk);
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++)
          applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), i, -1);
      end
      begin
        n = 0;
        while (acc_cnt < base + 3 && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        @(negedge clk);
        #3;
        checkOutput("stall_in_ready", longint'(in_ready), 0);
        checkOutput("stall_out_valid", longint'(out_valid), 1);
        repeat (3) @(negedge clk);
        #3;
        checkOutput("stall_in_ready_hold", longint'(in_ready), 0);
        checkOutput("stall_accepted", longint'(acc_cnt - base), 3);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with a full pipeline and a coincident input beat.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(17 * i + 3, 200 - i, 1'b0, 9, -1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_x = 8'd99; in_y = 8'd77; in_exact = 1'b1; in_tag = 4'd11;
    sb.delete();
    #3;
    checkOutput("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #3;
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_out_z", longint'(out_z), 0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

`ifdef APXMUL_ERRSTAT_EN
    out_ready = 1'b0;
    applyStimulus(255, 255, 1'b0, 2, 58944);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    stat_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_clr = 1'b0;
    #3;
    checkOutput("clr_err_cnt", longint'(err_cnt), 0);
    checkOutput("clr_err_sum", longint'(err_sum), 0);
`endif

    // Random mixed-mode traffic under random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int x, y;
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) x = 255;
      if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 1) ? 255 : 0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      applyStimulus(x, y, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), -1);
    end
    @(negedge clk);
    rand_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
